// File: rtl/clk_enable_scheduler.sv
// clk_enable_scheduler: per-channel /div tick and phase enables on one clock, with realigning FSM.
module clk_enable_scheduler #(
    parameter int NCH = 3,
    parameter int DW  = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           run,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [1:0]     cfg_ch,
    input  logic [DW-1:0]  cfg_div,
    output logic           cfg_err,
    output logic [NCH-1:0] tick,
    output logic [NCH-1:0] phase,
    output logic [1:0]     state
);
    typedef enum logic [1:0] {IDLE = 2'd0, ALIGN = 2'd1, RUN = 2'd2, UPDATE = 2'd3} state_t;

    state_t                   state_q, state_d;
    logic [NCH-1:0][DW-1:0]   div_q, div_d, cnt_q, cnt_d;
    logic [NCH-1:0]           tick_q, tick_d, phase_q, phase_d, hit;
    logic                     err_q, err_d, acc;

    assign cfg_ready = (state_q == IDLE) || (state_q == RUN);
    assign cfg_err   = err_q;
    assign tick      = tick_q;
    assign phase     = phase_q;
    assign state     = state_q;

    always_comb begin
        acc     = cfg_valid && cfg_ready;
        err_d   = acc && (int'(cfg_ch) >= NCH);
        div_d   = div_q;
        cnt_d   = '0;
        tick_d  = '0;
        phase_d = '0;
        hit     = '0;
        state_d = (state_q == RUN)  ? (!run ? IDLE : acc ? UPDATE : RUN) :
                  (state_q == IDLE) ? (run ? ALIGN : IDLE) :
                                      (run ? RUN : IDLE);
        for (int i = 0; i < NCH; i++) begin
            if (acc && int'(cfg_ch) == i)
                div_d[i] = (cfg_div == '0) ? DW'(1) : cfg_div;
            hit[i] = cnt_q[i] == div_q[i] - DW'(1);
        end
        // Counting only continues while RUN persists; any exit or realignment clears all channels.
        if (state_q == RUN && state_d == RUN) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_d[i]   = hit[i] ? '0 : cnt_q[i] + DW'(1);
                tick_d[i]  = hit[i];
                phase_d[i] = phase_q[i] ^ hit[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tick_q  <= '0;
            phase_q <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < NCH; i++)
                div_q[i] <= DW'(1 << i);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            phase_q <= phase_d;
            err_q   <= err_d;
            div_q   <= div_d;
        end
    end
endmodule
